// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and constants for the LFSR engine
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  localparam logic MODE_PRPG = 1'b0;
  localparam logic MODE_MISR = 1'b1;

  // Galois tap masks; bit 0 always set so the msb feeds back into bit 0
  localparam logic [3:0]  POLY4  = 4'h3;
  localparam logic [7:0]  POLY8  = 8'h1D;
  localparam logic [15:0] POLY16 = 16'h0071;
  localparam logic [31:0] POLY32 = 32'h0000_00C5;

  localparam logic [3:0]  SEED4  = 4'hF;
  localparam logic [7:0]  SEED8  = 8'hFF;
  localparam logic [15:0] SEED16 = 16'hFFFF;
  localparam logic [31:0] SEED32 = 32'hFFFF_FFFF;

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational Galois step, reusable by scan/BIST wrappers
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = POLY16
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] d,
  input  logic             mode,
  output logic [WIDTH-1:0] next_state
);

  logic [WIDTH-1:0] d_eff;
  logic             msb;

  always_comb begin
    d_eff      = (mode == MODE_MISR) ? d : '0;
    msb        = state[WIDTH-1];
    next_state = '0;
    next_state[0] = msb ^ d_eff[0];
    for (int i = 1; i < WIDTH; i++) begin
      next_state[i] = state[i-1] ^ (POLY[i] & msb) ^ d_eff[i];
    end
  end

endmodule

// File: rtl/lfsr_engine.sv
// rtl/lfsr_engine.sv - PRPG/MISR LFSR with counted-run control
module lfsr_engine
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] POLY     = POLY16,
  parameter logic [WIDTH-1:0] SEED     = SEED16,
  parameter int               OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mode,
  input  logic                load,
  input  logic [WIDTH-1:0]    seed_in,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                start,
  input  logic [15:0]         cnt_len,
  output logic [OUT_BITS-1:0] out,
  output logic [WIDTH-1:0]    state_out,
  output logic                busy,
  output logic                done,
  output logic                lockup
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] step_val;
  fsm_state_t       fsm_q, fsm_nxt;
  logic [15:0]      cnt_q, cnt_nxt;

  lfsr_next #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_next (
    .state      (state_q),
    .d          (data_in),
    .mode       (mode),
    .next_state (step_val)
  );

  assign lockup    = (state_q == '0) && (mode == MODE_PRPG);
  assign state_out = state_q;
  assign busy      = (fsm_q == ST_RUN);
  assign done      = (fsm_q == ST_DONE);

  // A stuck all-zero PRPG register is reseeded by the next enabled step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
      out     <= '0;
    end else begin
      out <= state_q[OUT_BITS-1:0];
      if (load) begin
        state_q <= seed_in;
      end else if (enable) begin
        state_q <= lockup ? SEED : step_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // A load cycle replaces the state but does not consume a count.
  always_comb begin
    fsm_nxt = fsm_q;
    cnt_nxt = cnt_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          cnt_nxt = cnt_len;
          fsm_nxt = (cnt_len != 16'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (enable && !load) begin
          cnt_nxt = cnt_q - 16'd1;
          if (cnt_q == 16'd1) fsm_nxt = ST_DONE;
        end
      end
      ST_DONE: fsm_nxt = ST_IDLE;
      default: fsm_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_engine.sv
// tb/tb_lfsr_engine.sv - directed scoreboard bench for lfsr_engine
module tb_lfsr_engine;

  logic        clk = 1'b0;
  logic        reset, enable, mode, load, start;
  logic [15:0] seed_in, data_in, cnt_len;
  logic [0:0]  out;
  logic [15:0] state_out;
  logic        busy, done, lockup;

  logic        enable4;
  logic [3:0]  seed_in4, data_in4;
  logic [1:0]  out4;
  logic [3:0]  state_out4;
  logic        busy4, done4, lockup4;

  always #5 clk = ~clk;

  lfsr_engine u_dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
    .seed_in(seed_in), .data_in(data_in), .start(start), .cnt_len(cnt_len),
    .out(out), .state_out(state_out), .busy(busy), .done(done), .lockup(lockup)
  );

  lfsr_engine #(.WIDTH(4), .POLY(4'h3), .SEED(4'h1), .OUT_BITS(2)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable4), .mode(1'b0), .load(1'b0),
    .seed_in(seed_in4), .data_in(data_in4), .start(1'b0), .cnt_len(16'd0),
    .out(out4), .state_out(state_out4), .busy(busy4), .done(done4), .lockup(lockup4)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] m;
  logic [3:0]  m4;
  int          busy_cnt, done_cnt, done_k, period;
  logic        zero_seen;

  // Shift-then-conditional-xor form; POLY bit 0 carries the msb into bit 0.
  function automatic logic [15:0] m16(logic [15:0] s, logic [15:0] d, logic md);
    logic [15:0] r;
    if (!md && s == 16'h0) return 16'hFFFF;
    r = {s[14:0], 1'b0} ^ (s[15] ? 16'h0071 : 16'h0000);
    if (md) r = r ^ d;
    return r;
  endfunction

  function automatic logic [3:0] m4step(logic [3:0] s);
    if (s == 4'h0) return 4'h1;
    return {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic sb_push(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL sb_empty: got %h, want a queued entry", obs);
    end else begin
      e = sb.pop_front();
      compare(e.tag, obs, e.exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0; load = 1'b0; start = 1'b0;
    seed_in = '0; data_in = '0; cnt_len = '0;
    enable4 = 1'b0; seed_in4 = '0; data_in4 = '0;
    tick();
    tick();
    compare("rst_state", state_out, 16'hFFFF);
    compare("rst_out", out, 0);
    compare("rst_busy", busy, 0);
    compare("rst_done", done, 0);
    compare("rst_lockup", lockup, 0);
    compare("rst_state4", state_out4, 4'h1);
    reset = 1'b0;
    m = 16'hFFFF;

    // single PRPG step from the default seed
    enable = 1'b1;
    m = m16(m, 16'h0, 1'b0);
    sb_push("prpg_step", m);
    tick();
    enable = 1'b0;
    sb_pop(state_out);
    compare("prpg_const", state_out, 16'hFF8F);
    compare("prpg_out", out, 1);

    // lockup and recovery
    load = 1'b1; seed_in = 16'h0000;
    tick();
    load = 1'b0; m = 16'h0000;
    compare("lockup_set", lockup, 1);
    compare("out_latency", out, 1);
    enable = 1'b1;
    m = m16(m, 16'h0, 1'b0);
    sb_push("lockup_recover", m);
    tick();
    enable = 1'b0;
    sb_pop(state_out);
    compare("recover_const", state_out, 16'hFFFF);
    compare("lockup_clear", lockup, 0);
    compare("out_zero_prev", out, 0);

    // MISR compaction, zero state is legal
    mode = 1'b1; load = 1'b1; seed_in = 16'h0000;
    tick();
    load = 1'b0; m = 16'h0000;
    compare("misr_no_lockup", lockup, 0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = (i == 0) ? 16'h0001 : ((i == 1) ? 16'hA5A5 : 16'h0F0F);
      m = m16(m, data_in, 1'b1);
      sb_push("misr_step", m);
      tick();
      sb_pop(state_out);
      if (i == 0) compare("misr_const", state_out, 16'h0001);
    end
    enable = 1'b0; mode = 1'b0; data_in = '0;

    // counted run of 5 with one stall; start held high while running
    load = 1'b1; seed_in = 16'h1234;
    tick();
    load = 1'b0; m = 16'h1234;
    start = 1'b1; cnt_len = 16'd5;
    tick();
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_k = -1;
    for (int k = 0; k < 12; k++) begin
      enable  = (k < 6 && k != 2);
      start   = (k >= 1 && k <= 5);
      cnt_len = 16'd9;
      if (enable) m = m16(m, 16'h0, 1'b0);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_k = k; end
      tick();
    end
    enable = 1'b0; start = 1'b0;
    compare("run5_busy_cycles", busy_cnt, 6);
    compare("run5_done_count", done_cnt, 1);
    compare("run5_done_at", done_k, 6);
    sb_push("run5_state", m);
    sb_pop(state_out);

    // load during a run consumes no count
    start = 1'b1; cnt_len = 16'd3;
    tick();
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_k = -1;
    for (int k = 0; k < 10; k++) begin
      enable  = (k < 4);
      load    = (k == 1);
      seed_in = 16'h00AA;
      if (load) m = 16'h00AA;
      else if (enable) m = m16(m, 16'h0, 1'b0);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_k = k; end
      tick();
    end
    enable = 1'b0; load = 1'b0;
    compare("runld_busy_cycles", busy_cnt, 4);
    compare("runld_done_at", done_k, 4);
    sb_push("runld_state", m);
    sb_pop(state_out);

    // zero-length run
    start = 1'b1; cnt_len = 16'd0;
    tick();
    start = 1'b0;
    compare("zero_done", done, 1);
    compare("zero_busy", busy, 0);
    sb_push("zero_state", m);
    sb_pop(state_out);
    tick();
    compare("zero_done_once", done, 0);
    compare("zero_busy_after", busy, 0);

    // reset aborts a run without a done pulse
    start = 1'b1; cnt_len = 16'd10;
    tick();
    start = 1'b0; enable = 1'b1;
    tick();
    tick();
    compare("abort_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compare("abort_state", state_out, 16'hFFFF);
    compare("abort_busy", busy, 0);
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      tick();
    end
    enable = 1'b0;
    compare("abort_no_done", done_cnt, 0);
    compare("abort_no_busy", busy_cnt, 0);

    // 4-bit maximal-length sequence
    enable4 = 1'b1; m4 = 4'h1; period = 0; zero_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      m4 = m4step(m4);
      sb_push("w4_state", m4);
      tick();
      sb_pop(state_out4);
      period++;
      if (state_out4 == 4'h0) zero_seen = 1'b1;
      if (state_out4 == 4'h1) break;
    end
    enable4 = 1'b0;
    compare("w4_period", period, 15);
    compare("w4_no_zero", zero_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
